// File: rtl/instr_loader.sv
// instr_loader: boot-time program loader.
// Receives LEN_HI, LEN_LO, then N big-endian 16-bit words as a byte stream,
// writes them to instruction memory from address 0 and releases the CPU
// reset once the session completes successfully.
// Optional feature macro: LOADER_CHECKSUM_EN (trailing XOR checksum byte).
module instr_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_data,
  output logic                  mem_we,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   word_count
);

  typedef enum logic [3:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA_HI,
    DATA_LO,
    WRITE,
`ifdef LOADER_CHECKSUM_EN
    CHECK,
`endif
    DONE,
    ERR
  } state_t;

  // Largest legal word count: the whole memory.
  localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_WIDTH;

  // State reached once the last word is written (or N == 0).
`ifdef LOADER_CHECKSUM_EN
  localparam state_t FINAL_STATE = CHECK;
`else
  localparam state_t FINAL_STATE = DONE;
`endif

  state_t                state_reg;
  state_t                state_next;
  logic [15:0]           len_reg;
  logic [7:0]            hi_reg;
  logic [7:0]            lo_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [ADDR_WIDTH:0]   count_reg;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            csum_reg;
`endif

  logic        accept;
  logic [31:0] len_full;
  logic [31:0] len_word;
  logic [31:0] count_plus;

  // Byte handshake and 32-bit views of the counters for comparisons.
  assign accept     = byte_valid && byte_ready;
  assign len_full   = {16'd0, len_reg[15:8], byte_data};
  assign len_word   = {16'd0, len_reg};
  assign count_plus = 32'(count_reg) + 32'd1;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE, ERR: begin
        if (start) state_next = LEN_HI;
      end
      LEN_HI: begin
        if (accept) state_next = LEN_LO;
      end
      LEN_LO: begin
        if (accept) begin
          if (len_full > MAX_WORDS)  state_next = ERR;
          else if (len_full == 32'd0) state_next = FINAL_STATE;
          else                        state_next = DATA_HI;
        end
      end
      DATA_HI: begin
        if (accept) state_next = DATA_LO;
      end
      DATA_LO: begin
        if (accept) state_next = WRITE;
      end
      WRITE: begin
        if (count_plus < len_word) state_next = DATA_HI;
        else                       state_next = FINAL_STATE;
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        if (accept) state_next = (byte_data == csum_reg) ? DONE : ERR;
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // Datapath: length capture, byte assembly, address/word counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      len_reg   <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      addr_reg  <= '0;
      count_reg <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_reg  <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE, DONE, ERR: begin
          if (start) begin
            addr_reg  <= '0;
            count_reg <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_reg  <= '0;
`endif
          end
        end
        LEN_HI: if (accept) len_reg[15:8] <= byte_data;
        LEN_LO: if (accept) len_reg[7:0]  <= byte_data;
        DATA_HI: if (accept) hi_reg <= byte_data;
        DATA_LO: if (accept) lo_reg <= byte_data;
        WRITE: begin
          // Address wraps to 0 after a full-memory load; no write follows.
          addr_reg  <= addr_reg + 1'b1;
          count_reg <= count_reg + 1'b1;
        end
        default: ;
      endcase
`ifdef LOADER_CHECKSUM_EN
      if (accept && state_reg != CHECK) csum_reg <= csum_reg ^ byte_data;
`endif
    end
  end

  // Outputs decoded purely from registered state and registers.
  always_comb begin
    byte_ready = (state_reg == LEN_HI) || (state_reg == LEN_LO) ||
`ifdef LOADER_CHECKSUM_EN
                 (state_reg == CHECK) ||
`endif
                 (state_reg == DATA_HI) || (state_reg == DATA_LO);
    busy       = !((state_reg == IDLE) || (state_reg == DONE) || (state_reg == ERR));
    done       = (state_reg == DONE);
    error      = (state_reg == ERR);
    cpu_reset  = (state_reg == DONE);
    mem_we     = (state_reg == WRITE);
    mem_addr   = addr_reg;
    mem_data   = {hi_reg, lo_reg};
    word_count = count_reg;
  end

endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: scoreboard bench for instr_loader. Expected memory writes
// are queued as words are streamed and popped when mem_we is seen.
module tb_instr_loader;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_data = 8'h00;
  logic          byte_ready;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_data;
  logic          mem_we;
  logic          cpu_reset;
  logic          busy;
  logic          done;
  logic          error;
  logic [AW:0]   word_count;

  int checks = 0;
  int errors = 0;
  int we_count = 0;
  int we_base;
  logic [AW+15:0] exp_q[$];
  logic [AW+15:0] exp_e;
  logic [15:0]    words[$];

  instr_loader #(.ADDR_WIDTH(AW), .WIDTH(16)) dut (
    .clk(clk), .reset(reset), .start(start),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Write monitor: one line per memory write, compared against the scoreboard.
  always @(negedge clk) begin
    if (!reset && mem_we === 1'b1) begin
      we_count++;
      $display("WRITE addr=%0h data=%04h", mem_addr, mem_data);
      if (exp_q.size() == 0) begin
        check("unexpected_we", 32'd1, 32'd0);
      end else begin
        exp_e = exp_q.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(exp_e[AW+15:16]));
        check("wr_data", 32'(mem_data), 32'(exp_e[15:0]));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int t;
    if (gap) begin
      @(negedge clk);
      byte_valid = 1'b0;
      byte_data  = 8'hEE;
    end
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    t = 0;
    while (byte_ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check("ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    byte_data  = 8'h5A;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_ready", 32'(byte_ready), 32'd1);
  endtask

  task automatic wait_settle();
    int t;
    t = 0;
    @(negedge clk);
    while (busy === 1'b1 && t < 8000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 8000) check("settle_timeout", 32'd1, 32'd0);
  endtask

  // Streams the words queue as one session; bad_csum corrupts the checksum byte.
  task automatic run_session(input bit gap, input logic [7:0] bad_csum);
    logic [15:0] n;
    logic [7:0]  x;
    n = 16'(words.size());
    x = n[15:8] ^ n[7:0];
    pulse_start();
    send_byte(n[15:8], gap);
    send_byte(n[7:0], gap);
    for (int i = 0; i < words.size(); i++) begin
      exp_q.push_back({AW'(i), words[i]});
      send_byte(words[i][15:8], gap);
      send_byte(words[i][7:0], gap);
      x = x ^ words[i][15:8] ^ words[i][7:0];
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(x ^ bad_csum, gap);
`else
    x = bad_csum;
`endif
    wait_settle();
  endtask

  task automatic check_done(input string tag, input int n);
    $display("SESSION %s words=%0d done=%0b error=%0b", tag, word_count, done, error);
    check({tag, "_wc"}, 32'(word_count), 32'(n));
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_cpu"}, 32'(cpu_reset), 32'd1);
    check({tag, "_err"}, 32'(error), 32'd0);
    check({tag, "_ready"}, 32'(byte_ready), 32'd0);
    check({tag, "_q"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(byte_ready), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_data", 32'(mem_data), 32'd0);
    check("rst_cpu", 32'(cpu_reset), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_wc", 32'(word_count), 32'd0);
    reset = 1'b0;

    // Basic two-word load, continuous valid.
    words = '{16'h1234, 16'hABCD};
    we_base = we_count;
    run_session(1'b0, 8'h00);
    check_done("basic", 2);
    check("basic_wes", 32'(we_count - we_base), 32'd2);

    // Same load with byte_valid toggling.
    we_base = we_count;
    run_session(1'b1, 8'h00);
    check_done("toggle", 2);
    check("toggle_wes", 32'(we_count - we_base), 32'd2);

    // Oversize length: 0x0401 > 1024 aborts after LEN_LO, no writes.
    we_base = we_count;
    pulse_start();
    send_byte(8'h04, 1'b0);
    send_byte(8'h01, 1'b0);
    wait_settle();
    $display("SESSION oversize done=%0b error=%0b", done, error);
    check("over_err", 32'(error), 32'd1);
    check("over_done", 32'(done), 32'd0);
    check("over_cpu", 32'(cpu_reset), 32'd0);
    check("over_wc", 32'(word_count), 32'd0);
    check("over_wes", 32'(we_count - we_base), 32'd0);

    // Zero-length session.
    words.delete();
    run_session(1'b0, 8'h00);
    check_done("zero", 0);

    // Full memory: 1024 words, address counter wraps back to 0.
    words.delete();
    for (int i = 0; i < 1024; i++) words.push_back(16'(i * 16'h1357) ^ 16'hA5A5);
    we_base = we_count;
    run_session(1'b0, 8'h00);
    check_done("full", 1024);
    check("full_wes", 32'(we_count - we_base), 32'd1024);
    check("full_wrap", 32'(mem_addr), 32'd0);

`ifdef LOADER_CHECKSUM_EN
    // Bad checksum: word still written, session ends in error.
    words = '{16'h1234};
    run_session(1'b0, 8'hFF);
    check("csum_err", 32'(error), 32'd1);
    check("csum_cpu", 32'(cpu_reset), 32'd0);
    check("csum_q", 32'(exp_q.size()), 32'd0);
`endif

    // Reset mid-session after the first write, then a clean reload.
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h03, 1'b0);
    exp_q.push_back({AW'(0), 16'h1111});
    send_byte(8'h11, 1'b0);
    send_byte(8'h11, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    $display("SESSION midreset busy=%0b wc=%0d", busy, word_count);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_cpu", 32'(cpu_reset), 32'd0);
    check("mid_wc", 32'(word_count), 32'd0);
    check("mid_addr", 32'(mem_addr), 32'd0);
    check("mid_q", 32'(exp_q.size()), 32'd0);
    words = '{16'hBEEF, 16'h0F0F};
    run_session(1'b1, 8'h00);
    check_done("reload", 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
